mac_arbiter: RTL and testbench

- Round-robin scheduler that shares one 2-stage square-accumulate MAC among NREQ requesters.
- Each requester sends a frame of FRAME_LEN 8-bit samples over a valid/ready handshake.
- Per frame, the block clears the MAC, streams the granted requester's samples into it, counts returned MAC valids, then posts the sum of squares tagged with the requester ID.
- Sits between the sample sources and the MAC datapath.

---
 rtl/mac_arbiter_if.sv | 31 +++
 rtl/mac_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_mac_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_arbiter_if.sv
// mac_arbiter_if: requester, MAC and result signals of the round-robin MAC arbiter.
// The slave modport is the arbiter's view; the master modport is the environment's view
// (sample sources, MAC datapath and result consumer).
interface mac_arbiter_if #(
  parameter int NREQ = 4
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ*8-1:0] req_a;
  logic [NREQ-1:0]   req_ready;
  logic [7:0]        mac_a;
  logic              mac_valid_in;
  logic              mac_clr;
  logic [19:0]       mac_f;
  logic              mac_valid_out;
  logic [19:0]       res_f;
  logic [IDW-1:0]    res_id;
  logic              res_valid;
  logic              res_err;

  modport slave (
    input  req_valid, req_a, mac_f, mac_valid_out,
    output req_ready, mac_a, mac_valid_in, mac_clr, res_f, res_id, res_valid, res_err
  );

  modport master (
    output req_valid, req_a, mac_f, mac_valid_out,
    input  req_ready, mac_a, mac_valid_in, mac_clr, res_f, res_id, res_valid, res_err
  );
endinterface

// File: rtl/mac_arbiter.sv
// mac_arbiter: round-robin scheduler sharing one square-accumulate MAC among NREQ
// requesters. Each frame: clear the MAC, stream FRAME_LEN samples of the granted
// requester, count returned MAC valids, then post the sum tagged with the requester ID.
// Optional macro MAC_ARB_TIMEOUT_EN: abort a frame after TIMEOUT consecutive stall
// cycles in STREAM and report it through res_err.
module mac_arbiter #(
  parameter int NREQ      = 4,
  parameter int FRAME_LEN = 4,
  parameter int TIMEOUT   = 15
) (
  input  logic         clk,
  input  logic         reset,
  mac_arbiter_if.slave bus
);
  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(FRAME_LEN + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_LEN - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CLEAR  = 3'd1;
  localparam logic [2:0] ST_STREAM = 3'd2;
  localparam logic [2:0] ST_DRAIN  = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  logic [2:0]     state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] gnt_q, gnt_d;
  logic [CW-1:0]  in_cnt_q, in_cnt_d;
  logic [CW-1:0]  out_cnt_q, out_cnt_d;
  logic [19:0]    res_f_q, res_f_d;
  logic [IDW-1:0] res_id_q, res_id_d;
  logic [IDW-1:0] pick_s;
  logic           mv_s;
  logic           frame_done_s;

`ifdef MAC_ARB_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STALL_LAST = SW'(TIMEOUT - 1);
  logic [SW-1:0] stall_cnt_q, stall_cnt_d;
  logic          err_q, err_d;
`endif

  // MAC results only count while a frame is in flight
  assign mv_s         = bus.mac_valid_out & ((state_q == ST_STREAM) | (state_q == ST_DRAIN));
  assign frame_done_s = mv_s & (out_cnt_q == LAST_CNT);

  // Round-robin pick: first requesting index at or above rr_ptr, wrapping around
  always_comb begin
    int             sum;
    logic [IDW-1:0] idx;
    pick_s = rr_ptr_q;
    for (int k = NREQ - 1; k >= 0; k--) begin
      sum    = int'(rr_ptr_q) + k;
      idx    = (sum >= NREQ) ? IDW'(sum - NREQ) : IDW'(sum);
      pick_s = bus.req_valid[idx] ? idx : pick_s;
    end
  end

  // Frame sequencing: grant, clear, stream, drain, post result
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    gnt_d     = gnt_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    res_f_d   = res_f_q;
    res_id_d  = res_id_q;
`ifdef MAC_ARB_TIMEOUT_EN
    stall_cnt_d = stall_cnt_q;
    err_d       = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        in_cnt_d  = '0;
        out_cnt_d = '0;
`ifdef MAC_ARB_TIMEOUT_EN
        stall_cnt_d = '0;
`endif
        if (|bus.req_valid) begin
          gnt_d   = pick_s;
          state_d = ST_CLEAR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        state_d = ST_STREAM;
      end
      ST_STREAM: begin
        out_cnt_d = out_cnt_q + CW'(mv_s);
        if (frame_done_s) begin
          state_d  = ST_DONE;
          res_f_d  = bus.mac_f;
          res_id_d = gnt_q;
`ifdef MAC_ARB_TIMEOUT_EN
          err_d = 1'b0;
`endif
        end else if (bus.req_valid[gnt_q]) begin
          in_cnt_d = in_cnt_q + CW'(1);
`ifdef MAC_ARB_TIMEOUT_EN
          stall_cnt_d = '0;
`endif
          state_d = (in_cnt_q == LAST_CNT) ? ST_DRAIN : ST_STREAM;
        end else begin
`ifdef MAC_ARB_TIMEOUT_EN
          if (stall_cnt_q == STALL_LAST) begin
            state_d  = ST_DONE;
            res_f_d  = 20'd0;
            res_id_d = gnt_q;
            err_d    = 1'b1;
          end else begin
            stall_cnt_d = stall_cnt_q + SW'(1);
          end
`else
          state_d = ST_STREAM;
`endif
        end
      end
      ST_DRAIN: begin
        out_cnt_d = out_cnt_q + CW'(mv_s);
        if (frame_done_s) begin
          state_d  = ST_DONE;
          res_f_d  = bus.mac_f;
          res_id_d = gnt_q;
`ifdef MAC_ARB_TIMEOUT_EN
          err_d = 1'b0;
`endif
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: begin
        rr_ptr_d = (gnt_q == IDW'(NREQ - 1)) ? '0 : gnt_q + IDW'(1);
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, grant, counter and result registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= '0;
      gnt_q     <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      res_f_q   <= 20'd0;
      res_id_q  <= '0;
`ifdef MAC_ARB_TIMEOUT_EN
      stall_cnt_q <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      gnt_q     <= gnt_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      res_f_q   <= res_f_d;
      res_id_q  <= res_id_d;
`ifdef MAC_ARB_TIMEOUT_EN
      stall_cnt_q <= stall_cnt_d;
      err_q       <= err_d;
`endif
    end
  end

  // Output decode from the registered state; the sample path follows the granted source
  always_comb begin
    bus.req_ready    = '0;
    bus.mac_a        = 8'd0;
    bus.mac_valid_in = 1'b0;
    bus.mac_clr      = (state_q == ST_CLEAR);
    bus.res_valid    = (state_q == ST_DONE);
    bus.res_f        = res_f_q;
    bus.res_id       = res_id_q;
`ifdef MAC_ARB_TIMEOUT_EN
    bus.res_err = err_q & (state_q == ST_DONE);
`else
    bus.res_err = 1'b0;
`endif
    if (state_q == ST_STREAM) begin
      bus.req_ready    = NREQ'(1) << gnt_q;
      bus.mac_a        = bus.req_a[{gnt_q, 3'b000} +: 8];
      bus.mac_valid_in = bus.req_valid[gnt_q];
    end else begin
      bus.req_ready    = '0;
    end
  end
endmodule

// File: tb/tb_mac_arbiter.sv
// tb_mac_arbiter: self-checking bench for mac_arbiter with a 2-stage square-accumulate
// MAC model, queue-driven requesters and a round-robin reference model.
module tb_mac_arbiter;
  localparam int NREQ = 4;
  localparam int FL   = 4;
  localparam int TO   = 15;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mac_arbiter_if #(.NREQ(NREQ)) bus ();
  mac_arbiter #(.NREQ(NREQ), .FRAME_LEN(FL), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .bus(bus));

  // Team MAC: stage 1 squares the sample, stage 2 accumulates and flags valid
  logic        v1_q, v2_q;
  logic [15:0] sq_q;
  logic [19:0] acc_q;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1_q <= 1'b0; v2_q <= 1'b0; sq_q <= 16'd0; acc_q <= 20'd0;
    end else if (bus.mac_clr) begin
      v1_q <= 1'b0; v2_q <= 1'b0; sq_q <= 16'd0; acc_q <= 20'd0;
    end else begin
      v1_q <= bus.mac_valid_in;
      sq_q <= {8'd0, bus.mac_a} * {8'd0, bus.mac_a};
      v2_q <= v1_q;
      if (v1_q) acc_q <= acc_q + {4'd0, sq_q};
    end
  end
  assign bus.mac_f         = acc_q;
  assign bus.mac_valid_out = v2_q;

  int n_checks = 0;
  int n_pass   = 0;

  // requester stimulus: sample value, or -1 for one stall cycle
  int src_buf [NREQ][64];
  int src_len [NREQ];
  int src_rd  [NREQ];
  // reference frames per requester
  int fr_sum  [NREQ][4];
  int fr_stall[NREQ][4];
  int fr_n    [NREQ];
  int cur_sum [NREQ];
  int cur_st  [NREQ];
  // observations
  int r_f[$], r_id[$], r_err[$], r_cyc[$], clr_cyc[$];
  int exp_f[$], exp_id[$], exp_lat[$];
  int cyc, acc_total, mvi_cnt, onehot_bad;

  task automatic clear_logs();
    r_f.delete(); r_id.delete(); r_err.delete(); r_cyc.delete(); clr_cyc.delete();
    cyc = 0; acc_total = 0; mvi_cnt = 0; onehot_bad = 0;
  endtask

  task automatic clear_src();
    for (int r = 0; r < NREQ; r++) begin
      src_len[r] = 0; src_rd[r] = 0; fr_n[r] = 0; cur_sum[r] = 0; cur_st[r] = 0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    bus.req_valid = '0;
    bus.req_a = '0;
    clear_src();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    clear_logs();
  endtask

  task automatic add_item(int r, int v);
    if (src_len[r] < 64) begin
      src_buf[r][src_len[r]] = v;
      src_len[r]++;
    end
  endtask

  // one sample of the current frame of requester r, followed by 'stalls' idle cycles
  task automatic frame_sample(int r, int v, int stalls);
    add_item(r, v);
    cur_sum[r] += v * v;
    for (int s = 0; s < stalls; s++) add_item(r, -1);
    cur_st[r] += stalls;
  endtask

  task automatic frame_end(int r);
    fr_sum[r][fr_n[r]]   = cur_sum[r];
    fr_stall[r][fr_n[r]] = cur_st[r];
    fr_n[r]++;
    cur_sum[r] = 0;
    cur_st[r]  = 0;
  endtask

  task automatic rand_frame(int r, int max_stall);
    for (int k = 0; k < FL; k++)
      frame_sample(r, int'($urandom_range(0, 255)), (k < FL - 1) ? int'($urandom_range(0, max_stall)) : 0);
    frame_end(r);
  endtask

  // Reference: round-robin over pending frames, pointer starting at 0 after reset
  task automatic build_expect();
    int pend[NREQ];
    int idx[NREQ];
    int ptr, total, r, c;
    exp_f.delete(); exp_id.delete(); exp_lat.delete();
    ptr = 0; total = 0;
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = fr_n[i]; idx[i] = 0; total += fr_n[i];
    end
    for (int n = 0; n < total; n++) begin
      r = 0;
      for (int k = 0; k < NREQ; k++) begin
        c = (ptr + k) % NREQ;
        if (pend[c] > 0) begin r = c; break; end
      end
      exp_id.push_back(r);
      exp_f.push_back(fr_sum[r][idx[r]]);
      exp_lat.push_back(FL + 3 + fr_stall[r][idx[r]]);
      idx[r]++; pend[r]--;
      ptr = (r + 1) % NREQ;
    end
  endtask

  // Drive requesters each negedge and observe outputs 1 time unit later (bounded)
  task automatic run(int max_cyc, int want_res, int want_acc);
    logic [NREQ-1:0]   v;
    logic [NREQ*8-1:0] a;
    for (int c = 0; c < max_cyc; c++) begin
      if (r_f.size() >= want_res) break;
      if (want_acc > 0 && acc_total >= want_acc) break;
      @(negedge clk);
      cyc++;
      v = '0; a = '0;
      for (int i = 0; i < NREQ; i++) begin
        if (src_rd[i] < src_len[i] && src_buf[i][src_rd[i]] >= 0) begin
          v[i] = 1'b1;
          a[i*8 +: 8] = 8'(src_buf[i][src_rd[i]]);
        end
      end
      bus.req_valid = v;
      bus.req_a = a;
      #1;
      if ($countones(bus.req_ready) > 1) onehot_bad++;
      if (bus.mac_clr) clr_cyc.push_back(cyc);
      if (bus.mac_valid_in) mvi_cnt++;
      if (bus.res_valid) begin
        r_f.push_back(int'(bus.res_f)); r_id.push_back(int'(bus.res_id));
        r_err.push_back(int'(bus.res_err)); r_cyc.push_back(cyc);
      end
      for (int i = 0; i < NREQ; i++) begin
        if (src_rd[i] < src_len[i]) begin
          if (src_buf[i][src_rd[i]] < 0) src_rd[i]++;
          else if (bus.req_ready[i]) begin src_rd[i]++; acc_total++; end
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.req_valid = '1;
    bus.req_a = {$urandom(), $urandom()};
    @(negedge clk); #1;
    n_checks++; if (bus.req_ready !== 4'd0) $display("FAIL reset_req_ready: got %0h want 0", bus.req_ready); else n_pass++;
    n_checks++; if (bus.mac_valid_in !== 1'b0) $display("FAIL reset_mac_valid_in: got %0b want 0", bus.mac_valid_in); else n_pass++;
    n_checks++; if (bus.mac_clr !== 1'b0) $display("FAIL reset_mac_clr: got %0b want 0", bus.mac_clr); else n_pass++;
    n_checks++; if (bus.mac_a !== 8'd0) $display("FAIL reset_mac_a: got %0d want 0", bus.mac_a); else n_pass++;
    n_checks++; if (bus.res_f !== 20'd0) $display("FAIL reset_res_f: got %0d want 0", bus.res_f); else n_pass++;
    n_checks++; if (bus.res_id !== 2'd0) $display("FAIL reset_res_id: got %0d want 0", bus.res_id); else n_pass++;
    n_checks++; if (bus.res_valid !== 1'b0) $display("FAIL reset_res_valid: got %0b want 0", bus.res_valid); else n_pass++;
    n_checks++; if (bus.res_err !== 1'b0) $display("FAIL reset_res_err: got %0b want 0", bus.res_err); else n_pass++;
    do_reset();
    run(4, 99, -1);
    n_checks++; if (clr_cyc.size() !== 0 || r_f.size() !== 0) $display("FAIL idle_no_request: got clr=%0d res=%0d want 0/0", clr_cyc.size(), r_f.size()); else n_pass++;
  endtask

  task automatic test_single();
    do_reset();
    frame_sample(0, 21, 0); frame_sample(0, 36, 0); frame_sample(0, 0, 0); frame_sample(0, 255, 0);
    frame_end(0);
    run(60, 1, -1);
    n_checks++; if (r_f.size() !== 1) $display("FAIL single_count: got %0d results want 1", r_f.size()); else n_pass++;
    if (r_f.size() >= 1 && clr_cyc.size() >= 1) begin
      n_checks++; if (r_f[0] !== 66762) $display("FAIL single_res_f: got %0d want 66762", r_f[0]); else n_pass++;
      n_checks++; if (r_id[0] !== 0) $display("FAIL single_res_id: got %0d want 0", r_id[0]); else n_pass++;
      n_checks++; if (r_cyc[0] - clr_cyc[0] !== 7) $display("FAIL single_latency: got %0d want 7", r_cyc[0] - clr_cyc[0]); else n_pass++;
    end
    n_checks++; if (clr_cyc.size() !== 1) $display("FAIL single_clr_pulses: got %0d want 1", clr_cyc.size()); else n_pass++;
    n_checks++; if (mvi_cnt !== 4) $display("FAIL single_mac_valid_in: got %0d want 4", mvi_cnt); else n_pass++;
    n_checks++; if (r_err.size() >= 1 && r_err[0] !== 0) $display("FAIL single_res_err: got %0d want 0", r_err[0]); else n_pass++;
  endtask

  task automatic test_two_req();
    do_reset();
    for (int k = 1; k <= 4; k++) begin frame_sample(0, k, 0); frame_sample(2, k, 0); end
    frame_end(0); frame_end(2);
    build_expect();
    run(100, 2, -1);
    n_checks++; if (r_f.size() !== 2) $display("FAIL two_req_count: got %0d want 2", r_f.size()); else n_pass++;
    for (int k = 0; k < 2 && k < r_f.size(); k++) begin
      n_checks++; if (r_id[k] !== exp_id[k]) $display("FAIL two_req_id%0d: got %0d want %0d", k, r_id[k], exp_id[k]); else n_pass++;
      n_checks++; if (r_f[k] !== exp_f[k]) $display("FAIL two_req_f%0d: got %0d want %0d", k, r_f[k], exp_f[k]); else n_pass++;
    end
    n_checks++; if (onehot_bad !== 0) $display("FAIL two_req_onehot: got %0d multi-grant cycles want 0", onehot_bad); else n_pass++;
  endtask

  task automatic test_stall();
    int lat0;
    lat0 = -1;
    do_reset();
    for (int k = 0; k < 4; k++) frame_sample(1, 10, 0);
    frame_end(1);
    run(60, 1, -1);
    if (r_f.size() >= 1 && clr_cyc.size() >= 1) lat0 = r_cyc[0] - clr_cyc[0];
    n_checks++; if (lat0 !== 7) $display("FAIL nostall_latency: got %0d want 7", lat0); else n_pass++;
    do_reset();
    frame_sample(1, 10, 3); frame_sample(1, 10, 0); frame_sample(1, 10, 0); frame_sample(1, 10, 0);
    frame_end(1);
    run(60, 1, -1);
    n_checks++; if (r_f.size() !== 1) $display("FAIL stall_count: got %0d want 1", r_f.size()); else n_pass++;
    if (r_f.size() >= 1 && clr_cyc.size() >= 1) begin
      n_checks++; if (r_f[0] !== 400) $display("FAIL stall_res_f: got %0d want 400", r_f[0]); else n_pass++;
      n_checks++; if (r_id[0] !== 1) $display("FAIL stall_res_id: got %0d want 1", r_id[0]); else n_pass++;
      n_checks++; if ((r_cyc[0] - clr_cyc[0]) - lat0 !== 3) $display("FAIL stall_delay: got %0d want 3", (r_cyc[0] - clr_cyc[0]) - lat0); else n_pass++;
    end
  endtask

  task automatic test_rotation();
    do_reset();
    rand_frame(0, 0); rand_frame(0, 0);
    rand_frame(1, 0); rand_frame(2, 0); rand_frame(3, 0);
    build_expect();
    run(200, 5, -1);
    n_checks++; if (r_f.size() !== 5) $display("FAIL rotation_count: got %0d want 5", r_f.size()); else n_pass++;
    for (int k = 0; k < 5 && k < r_f.size(); k++) begin
      n_checks++; if (r_id[k] !== exp_id[k]) $display("FAIL rotation_id%0d: got %0d want %0d", k, r_id[k], exp_id[k]); else n_pass++;
      n_checks++; if (r_f[k] !== exp_f[k]) $display("FAIL rotation_f%0d: got %0d want %0d", k, r_f[k], exp_f[k]); else n_pass++;
    end
    n_checks++; if (onehot_bad !== 0) $display("FAIL rotation_onehot: got %0d want 0", onehot_bad); else n_pass++;
  endtask

  task automatic test_random();
    int mask;
    for (int it = 0; it < 6; it++) begin
      do_reset();
      mask = int'($urandom_range(1, 15));
      for (int r = 0; r < NREQ; r++)
        if (mask[r]) for (int f = 0, nf = int'($urandom_range(1, 2)); f < nf; f++) rand_frame(r, 2);
      build_expect();
      run(400, exp_f.size(), -1);
      n_checks++; if (r_f.size() !== exp_f.size()) $display("FAIL random%0d_count: got %0d want %0d", it, r_f.size(), exp_f.size()); else n_pass++;
      for (int k = 0; k < exp_f.size() && k < r_f.size() && k < clr_cyc.size(); k++) begin
        n_checks++; if (r_id[k] !== exp_id[k]) $display("FAIL random%0d_id%0d: got %0d want %0d", it, k, r_id[k], exp_id[k]); else n_pass++;
        n_checks++; if (r_f[k] !== exp_f[k]) $display("FAIL random%0d_f%0d: got %0d want %0d", it, k, r_f[k], exp_f[k]); else n_pass++;
        n_checks++; if (r_cyc[k] - clr_cyc[k] !== exp_lat[k]) $display("FAIL random%0d_lat%0d: got %0d want %0d", it, k, r_cyc[k] - clr_cyc[k], exp_lat[k]); else n_pass++;
      end
      n_checks++; if (onehot_bad !== 0) $display("FAIL random%0d_onehot: got %0d want 0", it, onehot_bad); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 4; k++) frame_sample(0, 5, 0);
    frame_end(0);
    for (int k = 0; k < 4; k++) frame_sample(0, 7, 0);
    frame_end(0);
    run(60, 1, -1);
    acc_total = 0;
    run(60, 99, 2);
    @(posedge clk); #2;
    n_checks++; if (bus.req_ready !== 4'b0001) $display("FAIL mid_pre_ready: got %0h want 1", bus.req_ready); else n_pass++;
    reset = 1'b0;
    #1;
    n_checks++; if (bus.req_ready !== 4'd0 || bus.mac_valid_in !== 1'b0 || bus.mac_clr !== 1'b0 || bus.mac_a !== 8'd0)
      $display("FAIL mid_reset_stream_outs: got ready=%0h mvi=%0b clr=%0b a=%0d want all 0", bus.req_ready, bus.mac_valid_in, bus.mac_clr, bus.mac_a); else n_pass++;
    n_checks++; if (bus.res_f !== 20'd0 || bus.res_id !== 2'd0 || bus.res_valid !== 1'b0 || bus.res_err !== 1'b0)
      $display("FAIL mid_reset_res_outs: got f=%0d id=%0d v=%0b e=%0b want all 0", bus.res_f, bus.res_id, bus.res_valid, bus.res_err); else n_pass++;
    clear_src();
    bus.req_valid = '0;
    @(negedge clk);
    reset = 1'b1;
    clear_logs();
    run(20, 99, -1);
    n_checks++; if (r_f.size() !== 0) $display("FAIL mid_no_result: got %0d results want 0", r_f.size()); else n_pass++;
    for (int k = 0; k < 4; k++) frame_sample(0, 3, 0);
    frame_end(0);
    run(60, 1, -1);
    n_checks++; if (r_f.size() !== 1) $display("FAIL mid_next_count: got %0d want 1", r_f.size()); else n_pass++;
    if (r_f.size() >= 1) begin
      n_checks++; if (r_f[0] !== 36 || r_id[0] !== 0) $display("FAIL mid_next_frame: got f=%0d id=%0d want 36/0", r_f[0], r_id[0]); else n_pass++;
    end
  endtask

`ifdef MAC_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int s0, s1;
    do_reset();
    add_item(3, 1);
    run(80, 1, -1);
    n_checks++; if (r_f.size() !== 1) $display("FAIL timeout_count: got %0d want 1", r_f.size()); else n_pass++;
    if (r_f.size() >= 1 && clr_cyc.size() >= 1) begin
      n_checks++; if (r_err[0] !== 1 || r_id[0] !== 3 || r_f[0] !== 0) $display("FAIL timeout_result: got err=%0d id=%0d f=%0d want 1/3/0", r_err[0], r_id[0], r_f[0]); else n_pass++;
      n_checks++; if (r_cyc[0] - clr_cyc[0] !== 2 + TO) $display("FAIL timeout_latency: got %0d want %0d", r_cyc[0] - clr_cyc[0], 2 + TO); else n_pass++;
    end
    s0 = 0; s1 = 0;
    for (int k = 0; k < 4; k++) begin
      int a0, a1;
      a0 = int'($urandom_range(0, 255)); a1 = int'($urandom_range(0, 255));
      add_item(0, a0); add_item(1, a1); s0 += a0 * a0; s1 += a1 * a1;
    end
    run(100, 3, -1);
    n_checks++; if (r_f.size() !== 3) $display("FAIL timeout_after_count: got %0d want 3", r_f.size()); else n_pass++;
    if (r_f.size() >= 3) begin
      n_checks++; if (r_id[1] !== 0 || r_f[1] !== s0 || r_err[1] !== 0) $display("FAIL timeout_next_grant: got id=%0d f=%0d err=%0d want 0/%0d/0", r_id[1], r_f[1], r_err[1], s0); else n_pass++;
      n_checks++; if (r_id[2] !== 1 || r_f[2] !== s1) $display("FAIL timeout_third: got id=%0d f=%0d want 1/%0d", r_id[2], r_f[2], s1); else n_pass++;
    end
  endtask
`endif

  initial begin
    reset = 1'b0;
    bus.req_valid = '0;
    bus.req_a = '0;
    clear_src();
    clear_logs();
    test_reset();
    test_single();
    test_two_req();
    test_stall();
    test_rotation();
    test_random();
    test_reset_mid();
`ifdef MAC_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
